// File: rtl/qam_symbol_mapper.sv
// Serial-to-QAM symbol mapper: assembles BITS_PER_SYM bits, then releases them on a
// fixed symbol grid as Gray-decoded signed I/Q levels with sign flags.
module qam_symbol_mapper #(
  parameter int BITS_PER_SYM = 4,
  parameter int SYM_PERIOD   = 1024,
  parameter int LEVEL_W      = 8,
  parameter int STEP         = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  output logic signed [LEVEL_W-1:0] sym_i,
  output logic signed [LEVEL_W-1:0] sym_q,
  output logic                      elojel_cos,
  output logic                      elojel_sin,
  output logic                      sym_strobe,
  output logic                      underflow
);

  localparam int     H           = BITS_PER_SYM / 2;
  localparam int     M           = 1 << H;
  localparam int     TIMER_W     = $clog2(SYM_PERIOD);
  localparam int     CNT_W       = $clog2(BITS_PER_SYM + 1);
  localparam longint MAX_LEVEL   = longint'(M - 1) * longint'(STEP);
  localparam longint LEVEL_LIMIT = (longint'(1) << (LEVEL_W - 1)) - 1;

  if (BITS_PER_SYM < 2 || BITS_PER_SYM > 8 || (BITS_PER_SYM % 2) != 0) begin : g_bad_bits
    $error("qam_symbol_mapper: BITS_PER_SYM must be even and within 2..8");
  end
  if (SYM_PERIOD < 2 || SYM_PERIOD > 65535) begin : g_bad_period
    $error("qam_symbol_mapper: SYM_PERIOD must be within 2..65535");
  end
  if (LEVEL_W < 2 || LEVEL_W > 32 || STEP < 1 || MAX_LEVEL > LEVEL_LIMIT) begin : g_bad_level
    $error("qam_symbol_mapper: outermost level does not fit in signed LEVEL_W");
  end

  // Binary-reflected Gray decode of one half, then odd-integer level scaled by STEP.
  function automatic logic signed [LEVEL_W-1:0] gray_level(input logic [H-1:0] b);
    logic [H-1:0] g;
    int           lvl;
    g[H-1] = b[H-1];
    for (int k = H - 2; k >= 0; k--) begin
      g[k] = g[k+1] ^ b[k];
    end
    lvl = (2 * int'(g) - (M - 1)) * STEP;
    return LEVEL_W'(lvl);
  endfunction

  logic [TIMER_W-1:0]      timer;
  logic [BITS_PER_SYM-1:0] pending;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    boundary;
  logic                    pending_full;
  logic                    accept;
  logic signed [LEVEL_W-1:0] lvl_i;
  logic signed [LEVEL_W-1:0] lvl_q;

  assign boundary     = (timer == TIMER_W'(SYM_PERIOD - 1));
  assign pending_full = (bit_cnt == CNT_W'(BITS_PER_SYM));
  assign bit_ready    = ~rst & ~pending_full;
  assign accept       = bit_valid & bit_ready;

  assign lvl_i = gray_level(pending[H-1:0]);
  assign lvl_q = gray_level(pending[BITS_PER_SYM-1:H]);

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (boundary) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // NOTE: the assembly register is tiny and feeds the output mux directly, so it is
  // reset along with its counter; nothing stale may leak into a symbol after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      bit_cnt <= '0;
    end else if (boundary && pending_full) begin
      pending <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      for (int k = 0; k < BITS_PER_SYM; k++) begin
        if (bit_cnt == CNT_W'(k)) begin
          pending[k] <= bit_in;
        end
      end
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Partial assemblies survive an underflow boundary; only a load consumes bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_i      <= '0;
      sym_q      <= '0;
      elojel_cos <= 1'b0;
      elojel_sin <= 1'b0;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
      if (boundary) begin
        if (pending_full) begin
          sym_i      <= lvl_i;
          sym_q      <= lvl_q;
          elojel_cos <= lvl_i[LEVEL_W-1];
          elojel_sin <= lvl_q[LEVEL_W-1];
          sym_strobe <= 1'b1;
        end else begin
          sym_i      <= '0;
          sym_q      <= '0;
          elojel_cos <= 1'b0;
          elojel_sin <= 1'b0;
          underflow  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper with 16-QAM, 16-clock symbols, STEP 32, 8-bit levels.
module tb_qam_symbol_mapper;

  logic              clk;
  logic              rst;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic signed [7:0] sym_i;
  logic signed [7:0] sym_q;
  logic              elojel_cos;
  logic              elojel_sin;
  logic              sym_strobe;
  logic              underflow;

  qam_symbol_mapper #(
    .BITS_PER_SYM(4),
    .SYM_PERIOD  (16),
    .LEVEL_W     (8),
    .STEP        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .elojel_cos(elojel_cos),
    .elojel_sin(elojel_sin),
    .sym_strobe(sym_strobe),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        bits;   // bits[0] is sent first
    logic signed [7:0] exp_i;
    logic signed [7:0] exp_q;
    logic              exp_cos;
    logic              exp_sin;
  } vec_t;

  vec_t vec [16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic signed [7:0] ei,
                               input logic signed [7:0] eq, input logic ec,
                               input logic es);
    check({name, "_i"}, sym_i, ei);
    check({name, "_q"}, sym_q, eq);
    check({name, "_cos"}, elojel_cos, ec);
    check({name, "_sin"}, elojel_sin, es);
  endtask

  // Leaves the bench just after rst falls, i.e. in timer cycle 0.
  task automatic do_reset();
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("rst", 8'sd0, 8'sd0, 1'b0, 1'b0);
    check("rst_strobe", sym_strobe, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ready", bit_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bit_ready, 1);
  endtask

  // Called in timer cycle 0; sends bits[first +: nbits] in cycles 0.., then idles.
  // Returns in cycle 0 of the next period, where the boundary result is visible.
  task automatic run_period(input logic [3:0] bits, input int first, input int nbits,
                            output int n_strobe, output int n_under);
    n_strobe = 0;
    n_under  = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < nbits) begin
        bit_valid = 1'b1;
        bit_in    = bits[first+c];
      end else begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
      end
      @(negedge clk);
      if (sym_strobe === 1'b1) n_strobe++;
      if (underflow === 1'b1) n_under++;
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    int         ns;
    int         nu;
    int         idx;
    int         strobes;
    logic [3:0] cur;
    logic [3:0] nib;
    logic [3:0] sb_q[$];
    logic [15:0] stream;

    // 16-QAM: code b1b0 per half -> 00:-96 01:-32 11:+32 10:+96; I = bits[1:0], Q = bits[3:2]
    vec[0]  = '{4'd0,  -8'sd96, -8'sd96, 1'b1, 1'b1};
    vec[1]  = '{4'd1,  -8'sd32, -8'sd96, 1'b1, 1'b1};
    vec[2]  = '{4'd2,   8'sd96, -8'sd96, 1'b0, 1'b1};
    vec[3]  = '{4'd3,   8'sd32, -8'sd96, 1'b0, 1'b1};
    vec[4]  = '{4'd4,  -8'sd96, -8'sd32, 1'b1, 1'b1};
    vec[5]  = '{4'd5,  -8'sd32, -8'sd32, 1'b1, 1'b1};
    vec[6]  = '{4'd6,   8'sd96, -8'sd32, 1'b0, 1'b1};
    vec[7]  = '{4'd7,   8'sd32, -8'sd32, 1'b0, 1'b1};
    vec[8]  = '{4'd8,  -8'sd96,  8'sd96, 1'b1, 1'b0};
    vec[9]  = '{4'd9,  -8'sd32,  8'sd96, 1'b1, 1'b0};
    vec[10] = '{4'd10,  8'sd96,  8'sd96, 1'b0, 1'b0};
    vec[11] = '{4'd11,  8'sd32,  8'sd96, 1'b0, 1'b0};
    vec[12] = '{4'd12, -8'sd96,  8'sd32, 1'b1, 1'b0};
    vec[13] = '{4'd13, -8'sd32,  8'sd32, 1'b1, 1'b0};
    vec[14] = '{4'd14,  8'sd96,  8'sd32, 1'b0, 1'b0};
    vec[15] = '{4'd15,  8'sd32,  8'sd32, 1'b0, 1'b0};

    // Bits 1,1,0,0 then a boundary
    do_reset();
    run_period(4'b0011, 0, 4, ns, nu);
    check("first_strobes", ns, 1);
    check("first_strobe_now", sym_strobe, 1);
    check_outputs("first", 8'sd32, -8'sd96, 1'b0, 1'b1);
    check("first_ready_back", bit_ready, 1);
    @(negedge clk);
    check("first_strobe_width", sym_strobe, 0);
    check_outputs("first_hold", 8'sd32, -8'sd96, 1'b0, 1'b1);

    // All 16 nibbles back to back
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_period(vec[i].bits, 0, 4, ns, nu);
      check($sformatf("tbl%0d_strobes", i), ns, 1);
      check($sformatf("tbl%0d_under", i), nu, 0);
      check_outputs($sformatf("tbl%0d", i), vec[i].exp_i, vec[i].exp_q,
                    vec[i].exp_cos, vec[i].exp_sin);
    end
    run_period(4'd0, 0, 0, ns, nu);
    check("tbl_then_under", underflow, 1);
    check_outputs("tbl_then_under", 8'sd0, 8'sd0, 1'b0, 1'b0);

    // Idle input: underflow every period, no strobe
    do_reset();
    for (int p = 0; p < 3; p++) begin
      run_period(4'd0, 0, 0, ns, nu);
      check($sformatf("idle%0d_under", p), nu, 1);
      check($sformatf("idle%0d_strobes", p), ns, 0);
      check($sformatf("idle%0d_under_now", p), underflow, 1);
      check_outputs($sformatf("idle%0d", p), 8'sd0, 8'sd0, 1'b0, 1'b0);
    end

    // Two bits, an underflow boundary, two more bits: all four form the symbol
    do_reset();
    run_period(4'b1101, 0, 2, ns, nu);
    check("split_under", nu, 1);
    check("split_no_strobe", ns, 0);
    check_outputs("split_under", 8'sd0, 8'sd0, 1'b0, 1'b0);
    run_period(4'b1101, 2, 2, ns, nu);
    check("split_strobes", ns, 1);
    check("split_no_under", nu, 0);
    check_outputs("split", -8'sd32, 8'sd32, 1'b1, 1'b0);

    // bit_valid held high: scoreboard of accepted nibbles against decoded symbols
    do_reset();
    stream  = 16'b1011_0010_1110_0101;
    idx     = 0;
    strobes = 0;
    cur     = 4'd0;
    sb_q.delete();
    for (int c = 0; c <= 64; c++) begin
      check($sformatf("cont_ready_c%0d", c), bit_ready, ((c % 16) < 4) ? 1 : 0);
      check($sformatf("cont_strobe_c%0d", c), sym_strobe, (c > 0 && (c % 16) == 0) ? 1 : 0);
      if (sym_strobe === 1'b1) begin
        strobes++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cont_sb: strobe at cycle %0d, expected no symbol pending", c);
        end else begin
          nib = sb_q.pop_front();
          check("cont_i", sym_i, vec[int'(nib)].exp_i);
          check("cont_q", sym_q, vec[int'(nib)].exp_q);
        end
      end
      if (c < 64) begin
        bit_valid = 1'b1;
        bit_in    = (idx < 16) ? stream[idx] : 1'b0;
        if (bit_ready === 1'b1 && idx < 16) begin
          cur[idx%4] = stream[idx];
          idx++;
          if (idx % 4 == 0) sb_q.push_back(cur);
        end
        @(negedge clk);
      end
    end
    bit_valid = 1'b0;
    check("cont_strobe_total", strobes, 4);
    check("cont_bits_taken", idx, 16);

    // Reset at timer 9 with 3 bits pending discards them
    do_reset();
    run_period(4'b0011, 0, 4, ns, nu);
    check_outputs("pre_rst", 8'sd32, -8'sd96, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) begin
      bit_valid = (c < 3);
      bit_in    = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check_outputs("mid_rst", 8'sd0, 8'sd0, 1'b0, 1'b0);
    check("mid_rst_ready", bit_ready, 0);
    check("mid_rst_strobe", sym_strobe, 0);
    check("mid_rst_under", underflow, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bit_ready, 1);
    run_period(4'b0100, 0, 4, ns, nu);
    check("post_rst_strobes", ns, 1);
    check("post_rst_under", nu, 0);
    check_outputs("post_rst", -8'sd96, -8'sd32, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_mapper.md
QAM_SYMBOL_MAPPER -- requirements
Module: qam_symbol_mapper

Interface
REQ-001 Parameter BITS_PER_SYM, default 4: bits per QAM symbol; even, range 2..8 (2 = QPSK, 4 = 16-QAM).
REQ-002 Parameter SYM_PERIOD, default 1024: clocks per symbol; range 2..65535.
REQ-003 Parameter LEVEL_W, default 8: width of the signed I/Q level outputs.
REQ-004 Parameter STEP, default 32: amplitude unit. (2^(BITS_PER_SYM/2)-1)*STEP SHALL fit in signed LEVEL_W; otherwise elaboration SHALL fail.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 bit_in  in  1  serial data bit.
REQ-008 bit_valid  in  1  bit_in is valid this cycle.
REQ-009 bit_ready  out  1  mapper accepts a bit this cycle; a transfer occurs when bit_valid and bit_ready are both 1.
REQ-010 sym_i  out  LEVEL_W  signed in-phase level, registered.
REQ-011 sym_q  out  LEVEL_W  signed quadrature level, registered.
REQ-012 elojel_cos  out  1  sign of sym_i; 1 = negative. Registered.
REQ-013 elojel_sin  out  1  sign of sym_q; 1 = negative. Registered.
REQ-014 sym_strobe  out  1  one-cycle pulse when a new symbol appears on the outputs.
REQ-015 underflow  out  1  one-cycle pulse when a symbol boundary finds no complete symbol.

Function
REQ-016 The assembly register SHALL store accepted bits in arrival order: the first bit goes to pending[0] and the last to pending[BITS_PER_SYM-1]; a bit counter tracks the fill level.
REQ-017 bit_ready SHALL be 1 while the assembly register is not full and 0 while it is full; pending_full SHALL be set in the cycle after the last bit is accepted.
REQ-018 The symbol timer SHALL count 0..SYM_PERIOD-1 and wrap to 0; SYM_PERIOD-1 is the boundary cycle.
REQ-019 Boundary cycle with pending_full = 1 (load):
- In the next cycle, sym_i/sym_q/elojel_* SHALL show the new symbol and sym_strobe SHALL be 1.
- The assembly register and bit counter SHALL clear in that same cycle.
- bit_ready SHALL return to 1 in that same cycle.
REQ-020 Boundary cycle with pending_full = 0:
- In the next cycle, sym_i = 0, sym_q = 0, elojel_cos = 0, elojel_sin = 0, and underflow = 1.
- Partially assembled bits SHALL be kept and not discarded.
REQ-021 Outside a boundary load, outputs SHALL hold their value, and sym_strobe and underflow SHALL be 0.
REQ-022 Bit split: I = pending[H-1:0] and Q = pending[2H-1:H], where H = BITS_PER_SYM/2 and M = 2^H.
REQ-023 Gray decode per half: g[H-1] = b[H-1]; g[k] = g[k+1] XOR b[k].
REQ-024 Level = (2*g - (M-1)) * STEP, sign-extended to LEVEL_W; no saturation is needed by REQ-004.
REQ-025 In 16-QAM, I or Q bits map as: 00 -> -3*STEP, 01 -> -STEP, 11 -> +STEP, 10 -> +3*STEP.
REQ-026 In QPSK: bit 0 -> -STEP; bit 1 -> +STEP.
REQ-027 An accepted bit SHALL never be lost or duplicated, including when bit_valid is held continuously.

Reset
REQ-028 While rst = 1:
- sym_i = 0, sym_q = 0, elojel_cos = 0, elojel_sin = 0.
- sym_strobe = 0, underflow = 0, bit_ready = 0.
- Timer = 0; assembly register and bit counter cleared.
REQ-029 In the first cycle after rst falls, bit_ready SHALL be 1; the first boundary SHALL occur SYM_PERIOD-1 cycles after rst falls.
REQ-030 Reset asserted mid-symbol or mid-assembly SHALL discard all partial state within one clock.

Verification (bench: BITS_PER_SYM = 4, SYM_PERIOD = 16, STEP = 32, LEVEL_W = 8)
REQ-031 Send bits 1,1,0,0, then a boundary -> sym_i = +32, sym_q = -96, elojel_cos = 0, elojel_sin = 1, and sym_strobe pulses for 1 cycle.
REQ-032 Apply all 16 nibbles in sequence -> each I/Q pair equals the table in REQ-025; exactly one strobe per 16 clocks.
REQ-033 Hold bit_valid = 0 after reset -> underflow pulses every 16 clocks, outputs = 0, sym_strobe never asserts.
REQ-034 Send 2 bits, then wait for a boundary, then send 2 more bits -> underflow at the first boundary; the second boundary loads a symbol built from all 4 bits.
REQ-035 Hold bit_valid high continuously -> bit_ready = 0 for cycles 4..15 of each period, and no bits are lost (scoreboard compares the input stream against the decoded output).
REQ-036 Assert rst at timer = 9 with 3 bits pending -> all outputs = 0; after release, 4 new bits yield a symbol independent of the pre-reset bits.
